// File: rtl/vga_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_checker
// Description : Compares the pixels inside a rectangular view window of a
//               VGA frame against a stream of expected pixel words. It counts
//               in-window pixels and per-channel mismatches, remembers where
//               the first mismatch was seen, and reports done, abort,
//               underflow and short-frame status.
// Ports       : Clock_50 / Reset      - clock, synchronous active-high reset
//               Enable                - arms the checker, low returns to idle
//               Frame_start           - one-cycle pulse at frame start
//               Pixel_valid/X/Y/data  - observed pixel stream
//               Expected_valid/data   - expected-word source (ready/valid)
//               Expected_ready        - combinational pop strobe
//               Mismatch_count        - saturating channel-mismatch count
//               Pixel_count           - saturating in-window pixel count
//               Channel_mismatch      - per-channel result of last compare
//               First_X / First_Y     - coordinates of the first mismatch
//               Done/Abort/Underflow/Short_frame - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_checker #(
    parameter int CH_COUNT       = 3,
    parameter int CH_WIDTH       = 8,
    parameter int COORD_WIDTH    = 10,
    parameter int VIEW_LEFT      = 160,
    parameter int VIEW_RIGHT     = 480,
    parameter int VIEW_TOP       = 120,
    parameter int VIEW_BOTTOM    = 360,
    parameter int MAX_MISMATCHES = 10,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         Clock_50,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic                         Frame_start,
    input  logic                         Pixel_valid,
    input  logic [COORD_WIDTH-1:0]       Pixel_X,
    input  logic [COORD_WIDTH-1:0]       Pixel_Y,
    input  logic [CH_COUNT*CH_WIDTH-1:0] Pixel_data,
    input  logic                         Expected_valid,
    input  logic [CH_COUNT*CH_WIDTH-1:0] Expected_data,
    output logic                         Expected_ready,
    output logic [CNT_WIDTH-1:0]         Mismatch_count,
    output logic [CNT_WIDTH-1:0]         Pixel_count,
    output logic [CH_COUNT-1:0]          Channel_mismatch,
    output logic [COORD_WIDTH-1:0]       First_X,
    output logic [COORD_WIDTH-1:0]       First_Y,
    output logic                         Done,
    output logic                         Abort,
    output logic                         Underflow,
    output logic                         Short_frame
);

    localparam int c_NMIS_W = $clog2(CH_COUNT + 1);

    // Window bounds are held one bit wider and signed so that a bound of
    // zero compares cleanly against the zero-extended coordinate.
    localparam logic signed [COORD_WIDTH:0] c_LEFT   = (COORD_WIDTH+1)'(VIEW_LEFT);
    localparam logic signed [COORD_WIDTH:0] c_RIGHT  = (COORD_WIDTH+1)'(VIEW_RIGHT);
    localparam logic signed [COORD_WIDTH:0] c_TOP    = (COORD_WIDTH+1)'(VIEW_TOP);
    localparam logic signed [COORD_WIDTH:0] c_BOTTOM = (COORD_WIDTH+1)'(VIEW_BOTTOM);

    localparam logic [COORD_WIDTH-1:0] c_LAST_X  = COORD_WIDTH'(VIEW_RIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] c_LAST_Y  = COORD_WIDTH'(VIEW_BOTTOM - 1);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH:0]     c_MAX_MIS = (CNT_WIDTH+1)'(MAX_MISMATCHES);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CHECK      = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    state_t                 r_state_q,      w_state_d;
    logic [CNT_WIDTH-1:0]   r_mis_cnt_q,    w_mis_cnt_d;
    logic [CNT_WIDTH-1:0]   r_pix_cnt_q,    w_pix_cnt_d;
    logic [CH_COUNT-1:0]    r_chan_mis_q,   w_chan_mis_d;
    logic [COORD_WIDTH-1:0] r_first_x_q,    w_first_x_d;
    logic [COORD_WIDTH-1:0] r_first_y_q,    w_first_y_d;
    logic                   r_first_seen_q, w_first_seen_d;
    logic                   r_done_q,       w_done_d;
    logic                   r_abort_q,      w_abort_d;
    logic                   r_under_q,      w_under_d;
    logic                   r_short_q,      w_short_d;

    // ------------------------------------------------------------------
    // Window qualification and pop strobe
    // ------------------------------------------------------------------
    logic signed [COORD_WIDTH:0] w_x_s;
    logic signed [COORD_WIDTH:0] w_y_s;
    logic                        w_in_window;
    logic                        w_consume;
    logic                        w_last_pix;

    assign w_x_s = $signed({1'b0, Pixel_X});
    assign w_y_s = $signed({1'b0, Pixel_Y});

    assign w_in_window = (r_state_q == ST_CHECK) && Pixel_valid
                         && (w_x_s >= c_LEFT) && (w_x_s < c_RIGHT)
                         && (w_y_s >= c_TOP)  && (w_y_s < c_BOTTOM);

    assign w_consume      = w_in_window && Expected_valid;
    assign Expected_ready = w_consume;

    // Bottom-right pixel of the window closes the frame.
    assign w_last_pix = w_in_window && (Pixel_X == c_LAST_X) && (Pixel_Y == c_LAST_Y);

    // ------------------------------------------------------------------
    // Per-channel comparison; channel 0 occupies the most significant bits
    // ------------------------------------------------------------------
    logic [CH_COUNT-1:0] w_chan_diff;

    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_chan
        localparam int c_HI = (CH_COUNT - gi) * CH_WIDTH - 1;
        assign w_chan_diff[gi] = (Pixel_data[c_HI -: CH_WIDTH] != Expected_data[c_HI -: CH_WIDTH]);
    end

    logic [c_NMIS_W-1:0] w_diff_num;

    always_comb begin
        w_diff_num = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            w_diff_num = w_diff_num + c_NMIS_W'(w_chan_diff[i]);
        end
    end

    // Saturating counter arithmetic; the extra carry bit detects overflow.
    logic [CNT_WIDTH:0]   w_mis_sum;
    logic [CNT_WIDTH-1:0] w_mis_sat;
    logic [CNT_WIDTH-1:0] w_pix_inc;
    logic                 w_over_limit;

    assign w_mis_sum    = {1'b0, r_mis_cnt_q} + (CNT_WIDTH+1)'(w_diff_num);
    assign w_mis_sat    = w_mis_sum[CNT_WIDTH] ? c_CNT_MAX : w_mis_sum[CNT_WIDTH-1:0];
    assign w_over_limit = ({1'b0, w_mis_sat} > c_MAX_MIS);
    assign w_pix_inc    = (r_pix_cnt_q == c_CNT_MAX) ? r_pix_cnt_q
                                                     : r_pix_cnt_q + CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_mis_cnt_d    = r_mis_cnt_q;
        w_pix_cnt_d    = r_pix_cnt_q;
        w_chan_mis_d   = r_chan_mis_q;
        w_first_x_d    = r_first_x_q;
        w_first_y_d    = r_first_y_q;
        w_first_seen_d = r_first_seen_q;
        w_done_d       = r_done_q;
        w_abort_d      = r_abort_q;
        w_under_d      = r_under_q;
        w_short_d      = r_short_q;

        case (r_state_q)
            ST_IDLE: begin
                if (Enable) begin
                    w_state_d = ST_WAIT_FRAME;
                end
            end

            ST_WAIT_FRAME: begin
                // Entering CHECK starts a fresh measurement.
                if (Enable && Frame_start) begin
                    w_state_d      = ST_CHECK;
                    w_mis_cnt_d    = '0;
                    w_pix_cnt_d    = '0;
                    w_chan_mis_d   = '0;
                    w_first_x_d    = '0;
                    w_first_y_d    = '0;
                    w_first_seen_d = 1'b0;
                    w_done_d       = 1'b0;
                    w_abort_d      = 1'b0;
                    w_under_d      = 1'b0;
                    w_short_d      = 1'b0;
                end
            end

            ST_CHECK: begin
                if (w_in_window) begin
                    w_pix_cnt_d = w_pix_inc;
                    if (Expected_valid) begin
                        w_chan_mis_d = w_chan_diff;
                        w_mis_cnt_d  = w_mis_sat;
                        if ((|w_chan_diff) && !r_first_seen_q) begin
                            w_first_x_d    = Pixel_X;
                            w_first_y_d    = Pixel_Y;
                            w_first_seen_d = 1'b1;
                        end
                        if (w_over_limit) begin
                            w_abort_d = 1'b1;
                            w_done_d  = 1'b1;
                            w_state_d = ST_DONE;
                        end
                    end else begin
                        // Source ran dry: the pixel is counted but not compared.
                        w_under_d = 1'b1;
                    end
                    if (w_last_pix) begin
                        w_done_d  = 1'b1;
                        w_state_d = ST_DONE;
                    end
                end
                // A new frame before the window completed means the
                // previous frame was truncated.
                if (Frame_start) begin
                    w_short_d = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Results hold until the checker is disarmed.
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (!Enable) begin
            w_state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_state_q      <= ST_IDLE;
            r_mis_cnt_q    <= '0;
            r_pix_cnt_q    <= '0;
            r_chan_mis_q   <= '0;
            r_first_x_q    <= '0;
            r_first_y_q    <= '0;
            r_first_seen_q <= 1'b0;
            r_done_q       <= 1'b0;
            r_abort_q      <= 1'b0;
            r_under_q      <= 1'b0;
            r_short_q      <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_mis_cnt_q    <= w_mis_cnt_d;
            r_pix_cnt_q    <= w_pix_cnt_d;
            r_chan_mis_q   <= w_chan_mis_d;
            r_first_x_q    <= w_first_x_d;
            r_first_y_q    <= w_first_y_d;
            r_first_seen_q <= w_first_seen_d;
            r_done_q       <= w_done_d;
            r_abort_q      <= w_abort_d;
            r_under_q      <= w_under_d;
            r_short_q      <= w_short_d;
        end
    end

    assign Mismatch_count   = r_mis_cnt_q;
    assign Pixel_count      = r_pix_cnt_q;
    assign Channel_mismatch = r_chan_mis_q;
    assign First_X          = r_first_x_q;
    assign First_Y          = r_first_y_q;
    assign Done             = r_done_q;
    assign Abort            = r_abort_q;
    assign Underflow        = r_under_q;
    assign Short_frame      = r_short_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_checker
// Description : Directed bench for vga_frame_checker on a 4x2 view window
//               with an abort threshold of two. A frame-level model predicts
//               every output each cycle; literal checkpoints pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_checker;

    localparam int c_RIGHT  = 4;
    localparam int c_BOTTOM = 2;
    localparam int c_MAXMIS = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset, Enable, Frame_start, Pixel_valid, Expected_valid;
    logic [9:0]  Pixel_X, Pixel_Y;
    logic [23:0] Pixel_data, Expected_data;
    logic        Expected_ready;
    logic [15:0] Mismatch_count, Pixel_count;
    logic [2:0]  Channel_mismatch;
    logic [9:0]  First_X, First_Y;
    logic        Done, Abort, Underflow, Short_frame;

    vga_frame_checker #(
        .CH_COUNT      (3),
        .CH_WIDTH      (8),
        .COORD_WIDTH   (10),
        .VIEW_LEFT     (0),
        .VIEW_RIGHT    (c_RIGHT),
        .VIEW_TOP      (0),
        .VIEW_BOTTOM   (c_BOTTOM),
        .MAX_MISMATCHES(c_MAXMIS),
        .CNT_WIDTH     (16)
    ) dut (
        .Clock_50        (clk),
        .Reset           (Reset),
        .Enable          (Enable),
        .Frame_start     (Frame_start),
        .Pixel_valid     (Pixel_valid),
        .Pixel_X         (Pixel_X),
        .Pixel_Y         (Pixel_Y),
        .Pixel_data      (Pixel_data),
        .Expected_valid  (Expected_valid),
        .Expected_data   (Expected_data),
        .Expected_ready  (Expected_ready),
        .Mismatch_count  (Mismatch_count),
        .Pixel_count     (Pixel_count),
        .Channel_mismatch(Channel_mismatch),
        .First_X         (First_X),
        .First_Y         (First_Y),
        .Done            (Done),
        .Abort           (Abort),
        .Underflow       (Underflow),
        .Short_frame     (Short_frame)
    );

    // ------------------------------------------------------------------
    // Frame-level model: 0 disarmed, 1 armed, 2 measuring, 3 finished
    // ------------------------------------------------------------------
    int       m_phase;
    int       m_pix, m_mis, m_fx, m_fy;
    bit [2:0] m_chm;
    bit       m_first_seen, m_done, m_abort, m_under, m_short;
    bit       chk_on;

    function automatic bit coords_inside(input int x, input int y);
        return (x >= 0) && (x < c_RIGHT) && (y >= 0) && (y < c_BOTTOM);
    endfunction

    task automatic m_clear();
        m_pix = 0; m_mis = 0; m_fx = 0; m_fy = 0; m_chm = 3'b000;
        m_first_seen = 1'b0; m_done = 1'b0; m_abort = 1'b0;
        m_under = 1'b0; m_short = 1'b0;
    endtask

    always @(posedge clk) begin : model
        int px, py, n;
        bit [2:0] bits;
        chk_on = 1'b1;
        px = int'(Pixel_X);
        py = int'(Pixel_Y);
        if (Reset) begin
            m_phase = 0;
            m_clear();
        end else begin
            if (m_phase == 0) begin
                if (Enable) m_phase = 1;
            end else if (m_phase == 1) begin
                if (Enable && Frame_start) begin
                    m_phase = 2;
                    m_clear();
                end
            end else if (m_phase == 2) begin
                if (Pixel_valid && coords_inside(px, py)) begin
                    if (m_pix < 65535) m_pix = m_pix + 1;
                    if (Expected_valid) begin
                        n = 0;
                        bits = 3'b000;
                        for (int c = 0; c < 3; c++) begin
                            if (Pixel_data[23-8*c -: 8] != Expected_data[23-8*c -: 8]) begin
                                bits[c] = 1'b1;
                                n = n + 1;
                            end
                        end
                        m_chm = bits;
                        m_mis = (m_mis + n > 65535) ? 65535 : m_mis + n;
                        if (n > 0 && !m_first_seen) begin
                            m_first_seen = 1'b1;
                            m_fx = px;
                            m_fy = py;
                        end
                        if (m_mis > c_MAXMIS) begin
                            m_abort = 1'b1;
                            m_done  = 1'b1;
                            m_phase = 3;
                        end
                    end else begin
                        m_under = 1'b1;
                    end
                    if (px == c_RIGHT - 1 && py == c_BOTTOM - 1) begin
                        m_done  = 1'b1;
                        m_phase = 3;
                    end
                end
                if (Frame_start) begin
                    m_short = 1'b1;
                    m_done  = 1'b1;
                    m_phase = 3;
                end
            end
            if (!Enable) m_phase = 0;
        end
    end

    // ------------------------------------------------------------------
    // Checkpoint request from the stimulus, serviced by the compare process
    // ------------------------------------------------------------------
    int lit_req = 0;
    int lit_pc, lit_mc, lit_chm, lit_fx, lit_fy, lit_pops;
    bit lit_done, lit_abort, lit_under, lit_short;
    int pops_base = 0;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int lit_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit exp_rdy;
        if (chk_on) begin
            exp_rdy = (m_phase == 2) && Pixel_valid && Expected_valid
                      && coords_inside(int'(Pixel_X), int'(Pixel_Y));
            chk("ready",     32'(Expected_ready),   32'(exp_rdy));
            chk("mis_cnt",   32'(Mismatch_count),   32'(m_mis));
            chk("pix_cnt",   32'(Pixel_count),      32'(m_pix));
            chk("chan_mis",  32'(Channel_mismatch), 32'(m_chm));
            chk("first_x",   32'(First_X),          32'(m_fx));
            chk("first_y",   32'(First_Y),          32'(m_fy));
            chk("done",      32'(Done),             32'(m_done));
            chk("abort",     32'(Abort),            32'(m_abort));
            chk("underflow", 32'(Underflow),        32'(m_under));
            chk("short",     32'(Short_frame),      32'(m_short));

            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                chk("lit_pix_cnt", 32'(Pixel_count),      32'(lit_pc));
                chk("lit_mis_cnt", 32'(Mismatch_count),   32'(lit_mc));
                chk("lit_chan",    32'(Channel_mismatch), 32'(lit_chm));
                chk("lit_first_x", 32'(First_X),          32'(lit_fx));
                chk("lit_first_y", 32'(First_Y),          32'(lit_fy));
                chk("lit_done",    32'(Done),             32'(lit_done));
                chk("lit_abort",   32'(Abort),            32'(lit_abort));
                chk("lit_under",   32'(Underflow),        32'(lit_under));
                chk("lit_short",   32'(Short_frame),      32'(lit_short));
                chk("lit_pops",    32'(pops - pops_base), 32'(lit_pops));
            end

            // Pop for the cycle currently on the inputs.
            if (Expected_ready === 1'b1) pops = pops + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [23:0] pix_val(input int x, input int y);
        return 24'(32'h3C5A96 + x * 32'h010203 + y * 32'h102030);
    endfunction

    task automatic cyc(input bit en, input bit fs, input bit pv, input int x, input int y,
                       input logic [23:0] err, input bit ev);
        Enable         = en;
        Frame_start    = fs;
        Pixel_valid    = pv;
        Pixel_X        = x[9:0];
        Pixel_Y        = y[9:0];
        Expected_data  = pix_val(x, y);
        Pixel_data     = pix_val(x, y) ^ err;
        Expected_valid = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y, input logic [23:0] err, input bit ev);
        cyc(1'b1, 1'b0, 1'b1, x, y, err, ev);
    endtask

    task automatic start_frame();
        pops_base = pops;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 24'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic go_idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 24'h0, 1'b0);
    endtask

    task automatic lit(input int pc, input int mc, input bit dn, input bit ab, input bit un,
                       input bit sh, input int chm, input int fx, input int fy, input int np);
        lit_pc = pc; lit_mc = mc; lit_done = dn; lit_abort = ab; lit_under = un;
        lit_short = sh; lit_chm = chm; lit_fx = fx; lit_fy = fy; lit_pops = np;
        lit_req = lit_req + 1;
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; Frame_start = 1'b0; Pixel_valid = 1'b0;
        Pixel_X = '0; Pixel_Y = '0; Pixel_data = '0; Expected_data = '0; Expected_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        lit(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go_idle();

        // All eight pixels match; a gap cycle and an out-of-window pixel are ignored.
        start_frame();
        pixel(0, 0, 24'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1, 0, 24'h0, 1'b1);
        pixel(5, 0, 24'h0, 1'b1);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                if (!(x == 0 && y == 0)) pixel(x, y, 24'h0, 1'b1);
        lit(8, 0, 1, 0, 0, 0, 0, 0, 0, 8);
        pixel(0, 0, 24'h0, 1'b1);
        lit(8, 0, 1, 0, 0, 0, 0, 0, 0, 8);
        go_idle();

        // Channels 0 and 2 wrong at (1,0).
        start_frame();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                pixel(x, y, (x == 1 && y == 0) ? 24'hFF00FF : 24'h0, 1'b1);
                if (x == 1 && y == 0) lit(2, 2, 0, 0, 0, 0, 5, 1, 0, 2);
            end
        lit(8, 2, 1, 0, 0, 0, 0, 1, 0, 8);
        go_idle();

        // Second bad pixel crosses the threshold and aborts.
        start_frame();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                pixel(x, y, (y == 0 && x == 1) ? 24'hFF00FF :
                            (y == 0 && x == 2) ? 24'hFFFFFF : 24'h0, 1'b1);
        lit(3, 5, 1, 1, 0, 0, 7, 1, 0, 3);
        go_idle();

        // Expected source empty at (0,1).
        start_frame();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                pixel(x, y, 24'h0, !(x == 0 && y == 1));
        lit(8, 0, 1, 0, 1, 0, 0, 0, 0, 7);
        go_idle();

        // New frame after three pixels; a later Frame_start in DONE is ignored.
        start_frame();
        for (int x = 0; x < 3; x++) pixel(x, 0, 24'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 24'h0, 1'b0);
        lit(3, 0, 1, 0, 0, 1, 0, 0, 0, 3);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 24'h0, 1'b0);
        lit(3, 0, 1, 0, 0, 1, 0, 0, 0, 3);
        go_idle();

        // Channel packing, then reset in the middle of CHECK.
        start_frame();
        pixel(0, 0, 24'h010000, 1'b1);
        lit(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        pixel(1, 0, 24'h000080, 1'b1);
        lit(2, 2, 0, 0, 0, 0, 4, 0, 0, 2);
        pixel(5, 0, 24'h0, 1'b1);
        pixel(0, 3, 24'h0, 1'b1);
        Reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 24'h0, 1'b0);
        Reset = 1'b0;
        lit(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        go_idle();
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_checker.md
VGA_FRAME_CHECKER -- requirements
Module: vga_frame_checker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CH_COUNT, 3, colour channels per pixel.
- CH_WIDTH, 8, bits per channel.
- COORD_WIDTH, 10, pixel coordinate width.
- VIEW_LEFT / VIEW_RIGHT, 160 / 480, checked columns [LEFT, RIGHT).
- VIEW_TOP / VIEW_BOTTOM, 120 / 360, checked rows [TOP, BOTTOM).
- MAX_MISMATCHES, 10, abort threshold.
- CNT_WIDTH, 16, counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock_50, in, 1, sole clock.
- Reset, in, 1, synchronous, active-high.
- Enable, in, 1, arms the checker; low returns it to idle.
- Frame_start, in, 1, one-cycle pulse at frame start (Vsync falling).
- Pixel_valid, in, 1, qualifies Pixel_X, Pixel_Y and Pixel_data.
- Pixel_X, Pixel_Y, in, COORD_WIDTH each, coordinates of the current pixel.
- Pixel_data, in, CH_COUNT*CH_WIDTH, observed pixel; channel 0 in the MSBs.
- Expected_valid, in, 1, expected-data source has a word.
- Expected_data, in, CH_COUNT*CH_WIDTH, expected pixel, same packing.
- Expected_ready, out, 1, pops one expected word.
- Mismatch_count, out, CNT_WIDTH, saturating count of channel mismatches.
- Pixel_count, out, CNT_WIDTH, number of in-window pixels consumed.
- Channel_mismatch, out, CH_COUNT, per-channel result of the last comparison.
- First_X, First_Y, out, COORD_WIDTH each, coordinates of the first mismatch.
- Done, Abort, Underflow, Short_frame, out, 1 each, status flags.

Function
REQ-003 The block SHALL use states IDLE, WAIT_FRAME, CHECK and DONE.
REQ-004 The state machine SHALL make these transitions:
- IDLE to WAIT_FRAME when Enable=1.
- WAIT_FRAME to CHECK on Frame_start.
- Any state to IDLE when Enable=0, with priority below Reset.
REQ-005 On entry to CHECK the block SHALL clear all counters, flags and First_X/First_Y.
REQ-006 A pixel SHALL be in-window when all hold: CHECK state, Pixel_valid=1, VIEW_LEFT<=Pixel_X<VIEW_RIGHT, and VIEW_TOP<=Pixel_Y<VIEW_BOTTOM.
REQ-007 Expected_ready SHALL be a combinational output, equal to in-window AND Expected_valid; a word is consumed only when Expected_ready=1.
REQ-008 On consumption, the block SHALL compare each channel independently.
- Channel_mismatch[i] SHALL be registered one cycle later.
- Mismatch_count SHALL increase by the number of mismatching channels (0..CH_COUNT) and saturate at all-ones.
REQ-009 Pixel_count SHALL increment by 1 for every in-window pixel, including pixels skipped under REQ-011, and SHALL saturate.
REQ-010 On the first consumed pixel with any mismatch, the block SHALL latch First_X/First_Y; these SHALL not change again until the next CHECK entry.
REQ-011 For an in-window pixel with Expected_valid=0, the block SHALL set Underflow (sticky), perform no comparison and leave Mismatch_count unchanged.
REQ-012 When the updated Mismatch_count exceeds MAX_MISMATCHES, the block SHALL, on the same clock edge, set Abort, set Done and enter DONE.
REQ-013 When the in-window pixel at (VIEW_RIGHT-1, VIEW_BOTTOM-1) is processed, the block SHALL set Done and enter DONE on that edge.
- If that pixel also triggers REQ-012, both Done and Abort SHALL be set.
REQ-014 Frame_start received in CHECK SHALL set Short_frame and Done and move to DONE; Frame_start in IDLE or DONE SHALL be ignored.
REQ-015 In DONE, all outputs SHALL hold and Expected_ready SHALL be 0.
REQ-016 All outputs other than Expected_ready SHALL be registered.

Reset
REQ-017 When Reset=1 at a clock edge, the block SHALL enter IDLE and zero every registered output, including during CHECK.
REQ-018 After reset, Expected_ready SHALL be 0 until the next CHECK entry.

Verification
Scenarios use window LEFT=0, RIGHT=4, TOP=0, BOTTOM=2 and MAX_MISMATCHES=2:
REQ-019 Eight matching pixels with Expected_valid=1 -> Pixel_count=8, Mismatch_count=0, Done=1, Abort=0, eight pops.
REQ-020 Pixel (1,0) has channel 0 and channel 2 wrong -> Mismatch_count=2, Channel_mismatch=3'b101, First_X=1, First_Y=0, Done at (3,1), Abort=0.
REQ-021 Pixel (2,0) then has all 3 channels wrong -> Mismatch_count=5, Abort=1, Done=1, state DONE after pixel (2,0), no further pops.
REQ-022 Expected_valid=0 during pixel (0,1) -> Underflow=1, Pixel_count=8, seven pops, Mismatch_count=0.
REQ-023 Frame_start after 3 pixels -> Short_frame=1, Done=1, Pixel_count=3.
REQ-024 Reset asserted mid-CHECK -> next cycle all outputs 0, state IDLE; pixels (5,0) and (0,3) are never counted.
